decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder.sv | 153 +++++++++++++++
 tb/tb_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// rtl/decoder.sv - two-stage SECDED Hamming(16,11) decoder with saturating error counters
module decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             req,
    input  logic [15:0]      data_in,
    input  logic             cnt_clr,
    output logic             ack,
    output logic [7:0]       data_out,
    output logic             err_corr,
    output logic             err_uncorr,
    output logic [3:0]       syndrome,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    // Stage 1 registers: captured codeword with its syndrome and overall parity
    logic        s1_valid_q;
    logic [15:0] s1_cw_q;
    logic [3:0]  s1_syn_q;
    logic        s1_par_q;

    // Stage 2 registers drive the outputs directly
    logic        ack_q;
    logic [7:0]  data_q;
    logic        err_corr_q;
    logic        err_uncorr_q;
    logic [3:0]  syn_q;

    logic [CNT_W-1:0] corr_cnt_q,   corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

    logic        accept;
    logic [3:0]  syn_d;
    logic        par_d;

    logic [15:0] cw_fix;
    logic [10:0] d_fix;
    logic        flip;
    logic        dbl_err;
    logic        high_set;
    logic [7:0]  data_d;
    logic        err_corr_d;
    logic        err_uncorr_d;

    assign accept = en & req;

    // Syndrome is the XOR of the indices of all set bits in positions 1..15
    always_comb begin
        syn_d = 4'h0;
        par_d = ^data_in;
        for (int i = 1; i < 16; i++) begin
            if (data_in[i]) begin
                syn_d = syn_d ^ 4'(i);
            end
        end
    end

    // Stage 1: capture codeword on acceptance; valid drops when nothing is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_cw_q    <= 16'h0000;
            s1_syn_q   <= 4'h0;
            s1_par_q   <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_cw_q  <= data_in;
                s1_syn_q <= syn_d;
                s1_par_q <= par_d;
            end
        end
    end

    // Correction and classification of the stage-1 beat
    always_comb begin
        flip         = (s1_syn_q != 4'h0) && s1_par_q;
        dbl_err      = (s1_syn_q != 4'h0) && !s1_par_q;
        cw_fix       = s1_cw_q;
        if (flip) begin
            cw_fix = s1_cw_q ^ (16'h0001 << s1_syn_q);
        end
        d_fix        = {cw_fix[15:9], cw_fix[7:5], cw_fix[3]};
        high_set     = (d_fix[10:8] != 3'b000);
        data_d       = d_fix[7:0];
        err_uncorr_d = dbl_err || high_set;
        err_corr_d   = s1_par_q && !high_set;
    end

    // Stage 2: register results; flags and syndrome are zero outside ack, data holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q        <= 1'b0;
            data_q       <= 8'h00;
            err_corr_q   <= 1'b0;
            err_uncorr_q <= 1'b0;
            syn_q        <= 4'h0;
        end else begin
            ack_q <= s1_valid_q;
            if (s1_valid_q) begin
                data_q       <= data_d;
                err_corr_q   <= err_corr_d;
                err_uncorr_q <= err_uncorr_d;
                syn_q        <= s1_syn_q;
            end else begin
                err_corr_q   <= 1'b0;
                err_uncorr_q <= 1'b0;
                syn_q        <= 4'h0;
            end
        end
    end

    // Counter next-state: clear wins, otherwise saturating increment on flagged ack
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else begin
            if (ack_q && err_corr_q && (corr_cnt_q != {CNT_W{1'b1}})) begin
                corr_cnt_d = corr_cnt_q + 1'b1;
            end
            if (ack_q && err_uncorr_q && (uncorr_cnt_q != {CNT_W{1'b1}})) begin
                uncorr_cnt_d = uncorr_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign ack        = ack_q;
    assign data_out   = data_q;
    assign err_corr   = err_corr_q;
    assign err_uncorr = err_uncorr_q;
    assign syndrome   = syn_q;
    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - scoreboard bench for the SECDED decoder
module tb_decoder;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        req;
    logic [15:0] data_in;
    logic        cnt_clr;
    logic        ack;
    logic [7:0]  data_out;
    logic        err_corr;
    logic        err_uncorr;
    logic [3:0]  syndrome;
    logic [7:0]  corr_cnt;
    logic [7:0]  uncorr_cnt;

    typedef struct {
        logic [7:0] d;
        logic       c;
        logic       u;
        logic [3:0] s;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    decoder #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req        (req),
        .data_in    (data_in),
        .cnt_clr    (cnt_clr),
        .ack        (ack),
        .data_out   (data_out),
        .err_corr   (err_corr),
        .err_uncorr (err_uncorr),
        .syndrome   (syndrome),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every ack against the head of the scoreboard
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=1 expected no ack (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("ack_latency", cyc, e.cyc);
                check("data_out", {24'h0, data_out}, {24'h0, e.d});
                check("err_corr", {31'h0, err_corr}, {31'h0, e.c});
                check("err_uncorr", {31'h0, err_uncorr}, {31'h0, e.u});
                check("syndrome", {28'h0, syndrome}, {28'h0, e.s});
            end
        end else begin
            check("idle_flags", {27'h0, err_corr, err_uncorr, syndrome},
                  32'h0);
        end
    end

    task automatic send(input logic [15:0] cw, input logic [7:0] d, input logic c,
                        input logic u, input logic [3:0] s, input bit push);
        en      = 1'b1;
        req     = 1'b1;
        data_in = cw;
        if (push) q.push_back('{d: d, c: c, u: u, s: s, cyc: cyc + 2});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        en  = 1'b0;
        req = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n   = 1'b1;
        en      = 1'b0;
        req     = 1'b0;
        data_in = 16'h0000;
        cnt_clr = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_data", {24'h0, data_out}, 32'h0);
        check("rst_cnts", {16'h0, corr_cnt, uncorr_cnt}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // First beat right after reset release, then back-to-back error cases
        send(16'h144E, 8'hA5, 1'b0, 1'b0, 4'h0, 1'b1);
        send(16'h140E, 8'hA5, 1'b1, 1'b0, 4'h6, 1'b1);
        send(16'h144F, 8'hA5, 1'b1, 1'b0, 4'h0, 1'b1);
        send(16'h1406, 8'hA0, 1'b0, 1'b1, 4'h5, 1'b1);
        send(16'h2112, 8'h00, 1'b0, 1'b1, 4'h0, 1'b1);
        // req without en must be ignored
        en      = 1'b0;
        req     = 1'b1;
        data_in = 16'h140E;
        @(posedge clk);
        #1;
        idle(5);
        check("corr_cnt_mix", {24'h0, corr_cnt}, 32'd2);
        check("uncorr_cnt_mix", {24'h0, uncorr_cnt}, 32'd2);
        check("drain_mix", q.size(), 32'd0);

        // Reset with a beat sitting in stage 1: outputs clear at once, no ack follows
        send(16'h144E, 8'hA5, 1'b0, 1'b0, 4'h0, 1'b0);
        en  = 1'b0;
        req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ack", {31'h0, ack}, 32'h0);
        check("midrst_data", {24'h0, data_out}, 32'h0);
        check("midrst_cnts", {16'h0, corr_cnt, uncorr_cnt}, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle(5);

        // Saturation: 2^8+3 corrected beats
        for (int i = 0; i < 259; i++) begin
            send(16'h140E, 8'hA5, 1'b1, 1'b0, 4'h6, 1'b1);
        end
        idle(4);
        check("corr_cnt_sat", {24'h0, corr_cnt}, 32'hFF);
        check("uncorr_cnt_sat", {24'h0, uncorr_cnt}, 32'h0);

        // Clear coincident with a corrected ack
        send(16'h140E, 8'hA5, 1'b1, 1'b0, 4'h6, 1'b1);
        en  = 1'b0;
        req = 1'b0;
        @(posedge clk);
        #1;
        check("ack_before_clr", {31'h0, ack}, 32'h1);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("corr_cnt_clr", {24'h0, corr_cnt}, 32'h0);
        @(posedge clk);
        #1;
        check("corr_cnt_clr_hold", {24'h0, corr_cnt}, 32'h0);

        idle(4);
        check("scoreboard_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
